// File: rtl/i2s_pkg.sv
// ============================================================================
//  Module  : i2s_pkg
//  Brief   : Shared I2S constants, slot phase type and clog2 helper.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

  localparam int   SLOT_W     = 32;
  localparam int   FRAME_BITS = 64;
  localparam logic WS_LEFT    = 1'b0;

  typedef enum logic {
    LEFT_SLOT  = 1'b0,
    RIGHT_SLOT = 1'b1
  } slot_e;

  // Ceiling log2, never below 1 so derived vectors always have a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_tx_serializer_if.sv
// ============================================================================
//  Module  : i2s_tx_serializer_if
//  Brief   : Sample input bus and I2S/status outputs of the I2S transmitter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface i2s_tx_serializer_if #(
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 4
);
  import i2s_pkg::*;

  localparam int LVL_W = clog2(FIFO_DEPTH) + 1;

  logic [SAMPLE_W-1:0] APSDATA_LEFT_i;
  logic [SAMPLE_W-1:0] APSDATA_RIGHT_i;
  logic                APDATA_VALID_i;
  logic                I2S_BCK;
  logic                I2S_WS;
  logic                I2S_DATA;
  logic [LVL_W-1:0]    FIFO_LEVEL_o;
  logic                UNDERRUN_o;
  logic                OVERFLOW_o;

  modport master (
    output APSDATA_LEFT_i, APSDATA_RIGHT_i, APDATA_VALID_i,
    input  I2S_BCK, I2S_WS, I2S_DATA, FIFO_LEVEL_o, UNDERRUN_o, OVERFLOW_o
  );

  modport slave (
    input  APSDATA_LEFT_i, APSDATA_RIGHT_i, APDATA_VALID_i,
    output I2S_BCK, I2S_WS, I2S_DATA, FIFO_LEVEL_o, UNDERRUN_o, OVERFLOW_o
  );

endinterface

`default_nettype wire

// File: rtl/i2s_tx_fifo.sv
// ============================================================================
//  Module  : i2s_tx_fifo
//  Brief   : Synchronous sample-pair FIFO with registered occupancy level.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_push,
  input  wire logic [WIDTH-1:0]         i_wdata,
  input  wire logic                     i_pop,
  output logic      [WIDTH-1:0]         o_rdata,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [clog2(DEPTH):0]    o_level
);

  localparam int c_AW    = clog2(DEPTH);
  localparam int c_LVL_W = c_AW + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic               w_full;
  logic               w_empty;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_full    = (r_level == c_LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  // A simultaneous pop frees the slot being written, so full does not block.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= (r_wr_ptr == c_AW'(DEPTH - 1)) ? '0 : r_wr_ptr + c_AW'(1);
      if (w_do_pop)
        r_rd_ptr <= (r_rd_ptr == c_AW'(DEPTH - 1)) ? '0 : r_rd_ptr + c_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/i2s_tx_serializer.sv
// ============================================================================
//  Module  : i2s_tx_serializer
//  Brief   : Parallel-to-I2S master transmitter, Philips format, 32-bit slots.
//            Define I2S_TX_DOWNSAMPLE_2X_EN to keep only every other strobe.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = 24,
  parameter int BCK_HALF   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic          AMCLK_i,
  input  wire logic          ARST_i,
  i2s_tx_serializer_if.slave bus
);

  localparam int c_DIV_W  = clog2(BCK_HALF);
  localparam int c_LVL_W  = clog2(FIFO_DEPTH) + 1;
  localparam int c_PAIR_W = 2 * SAMPLE_W;

  logic [1:0]            r_rst_pipe;
  logic                  w_rst;
  logic [c_DIV_W-1:0]    r_div_cnt;
  logic                  r_bck;
  logic                  r_ws;
  logic                  r_data;
  logic                  r_underrun;
  logic                  r_overflow;
  logic [5:0]            r_bit_cnt;
  logic [5:0]            w_bit_nxt;
  logic [FRAME_BITS-1:0] r_frame;
  logic [FRAME_BITS-1:0] w_frame_word;
  logic [c_PAIR_W-1:0]   r_last_pair;
  logic [c_PAIR_W-1:0]   w_head_pair;
  logic [c_PAIR_W-1:0]   w_fifo_rdata;
  logic [SLOT_W-1:0]     w_left_slot;
  logic [SLOT_W-1:0]     w_right_slot;
  logic [c_LVL_W-1:0]    w_level;
  logic                  w_tick;
  logic                  w_fall;
  logic                  w_load;
  logic                  w_pop;
  logic                  w_wr_cand;
  logic                  w_drop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  slot_e                 w_phase_nxt;

  // Asynchronous assertion, release synchronised to AMCLK.
  always_ff @(posedge AMCLK_i or posedge ARST_i) begin
    if (ARST_i) r_rst_pipe <= 2'b11;
    else        r_rst_pipe <= {r_rst_pipe[0], 1'b0};
  end
  assign w_rst = r_rst_pipe[1];

`ifdef I2S_TX_DOWNSAMPLE_2X_EN
  logic r_ds_toggle;
  always_ff @(posedge AMCLK_i or posedge w_rst) begin
    if (w_rst)                   r_ds_toggle <= 1'b0;
    else if (bus.APDATA_VALID_i) r_ds_toggle <= ~r_ds_toggle;
  end
  assign w_wr_cand = bus.APDATA_VALID_i & ~r_ds_toggle;
`else
  assign w_wr_cand = bus.APDATA_VALID_i;
`endif

  assign w_tick      = (r_div_cnt == c_DIV_W'(BCK_HALF - 1));
  assign w_fall      = w_tick & r_bck;
  assign w_bit_nxt   = r_bit_cnt + 6'd1;
  assign w_phase_nxt = slot_e'(w_bit_nxt[5]);
  assign w_load      = w_fall & (r_bit_cnt == 6'd63);
  assign w_pop       = w_load & ~w_fifo_empty;
  assign w_drop      = w_wr_cand & w_fifo_full & ~w_pop;

  i2s_tx_fifo #(
    .WIDTH (c_PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (AMCLK_i),
    .rst     (w_rst),
    .i_push  (w_wr_cand),
    .i_wdata ({bus.APSDATA_LEFT_i, bus.APSDATA_RIGHT_i}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_level)
  );

  // Each sample sits one slot below the WS edge, MSB first, zero-padded below.
  assign w_head_pair  = w_pop ? w_fifo_rdata : r_last_pair;
  assign w_left_slot  = SLOT_W'(w_head_pair[c_PAIR_W-1:SAMPLE_W]) << (SLOT_W - 1 - SAMPLE_W);
  assign w_right_slot = SLOT_W'(w_head_pair[SAMPLE_W-1:0]) << (SLOT_W - 1 - SAMPLE_W);
  assign w_frame_word = {w_left_slot, w_right_slot};

  always_ff @(posedge AMCLK_i or posedge w_rst) begin
    if (w_rst) begin
      r_div_cnt   <= '0;
      r_bck       <= 1'b0;
      r_ws        <= 1'b0;
      r_data      <= 1'b0;
      r_bit_cnt   <= '0;
      r_frame     <= '0;
      r_last_pair <= '0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      r_overflow <= w_drop;

      if (w_tick) begin
        r_div_cnt <= '0;
        r_bck     <= ~r_bck;
      end else begin
        r_div_cnt <= r_div_cnt + c_DIV_W'(1);
      end

      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_ws      <= (w_phase_nxt == LEFT_SLOT) ? WS_LEFT : ~WS_LEFT;
        if (w_load) begin
          r_frame     <= w_frame_word << 1;
          r_data      <= w_frame_word[FRAME_BITS-1];
          r_last_pair <= w_head_pair;
          r_underrun  <= w_fifo_empty;
        end else begin
          r_frame <= r_frame << 1;
          r_data  <= r_frame[FRAME_BITS-1];
        end
      end
    end
  end

  assign bus.I2S_BCK      = r_bck;
  assign bus.I2S_WS       = r_ws;
  assign bus.I2S_DATA     = r_data;
  assign bus.FIFO_LEVEL_o = w_level;
  assign bus.UNDERRUN_o   = r_underrun;
  assign bus.OVERFLOW_o   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_serializer.sv
// ============================================================================
//  Module  : tb_i2s_tx_serializer
//  Brief   : Scoreboard bench for i2s_tx_serializer (BCK_HALF=4, 512-cycle frames).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2s_tx_serializer;

  localparam int SW        = 24;
  localparam int BH        = 4;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = 2 * BH * 64;
  localparam logic [63:0] WS_EXP = 64'h0000_0000_FFFF_FFFF;

  logic AMCLK_i = 1'b0;
  logic ARST_i  = 1'b1;

  i2s_tx_serializer_if #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) bus();

  i2s_tx_serializer #(
    .SAMPLE_W   (SW),
    .BCK_HALF   (BH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .AMCLK_i (AMCLK_i),
    .ARST_i  (ARST_i),
    .bus     (bus)
  );

  always #5 AMCLK_i = ~AMCLK_i;

  int total = 0;
  int bad   = 0;

  longint cyc = 0;
  longint rel = 0;
  always @(posedge AMCLK_i) cyc++;

  // Reference model state
  logic [2*SW-1:0] mq[$];
  logic [2*SW-1:0] last_pair = '0;
  logic [63:0]     sb[$];
  int              pcount  = 0;
  int              exp_under = 0;
  int              exp_ovf   = 0;
  bit              ds_tog  = 1'b0;

  // Monitor state
  int          mon_under = 0;
  int          mon_ovf   = 0;
  int          slot      = 0;
  int          half_cnt  = 0;
  bit          first_tog = 1'b1;
  logic        prev_bck  = 1'b0;
  logic [63:0] cap_d     = '0;
  logic [63:0] cap_ws    = '0;
  logic [63:0] exp_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Slot s of the frame lives at bit 63-s.
  function automatic logic [63:0] frame_word(input logic [2*SW-1:0] p);
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic [63:0]   w;
    l = p[2*SW-1:SW];
    r = p[SW-1:0];
    w = '0;
    for (int s = 1; s <= SW; s++) begin
      w[63 - s]      = l[SW - s];
      w[63 - 32 - s] = r[SW - s];
    end
    return w;
  endfunction

  always @(negedge AMCLK_i) begin
    if (ARST_i) begin
      slot      = 0;
      prev_bck  = 1'b0;
      half_cnt  = 0;
      first_tog = 1'b1;
    end else begin
      if (bus.UNDERRUN_o) mon_under++;
      if (bus.OVERFLOW_o) mon_ovf++;
      half_cnt++;
      if (bus.I2S_BCK !== prev_bck) begin
        if (!first_tog) check("bck_half_period", 64'(half_cnt), 64'(BH));
        first_tog = 1'b0;
        half_cnt  = 0;
        if (bus.I2S_BCK === 1'b1) begin
          cap_d[63 - slot]  = bus.I2S_DATA;
          cap_ws[63 - slot] = bus.I2S_WS;
          if (slot == 63) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("FAIL frame_unexpected: got frame 0x%0h, want none queued", cap_d);
            end else begin
              exp_w = sb.pop_front();
              check("frame_data", cap_d, exp_w);
              check("frame_ws", cap_ws, WS_EXP);
            end
          end
          slot = (slot + 1) % 64;
        end
      end
      prev_bck = bus.I2S_BCK;
    end
  end

  task automatic tick();
    @(posedge AMCLK_i);
    #1;
  endtask

  task automatic wait_until(input longint c);
    while (cyc - rel < c) tick();
  endtask

  // Frame boundary: the DUT loads the next pair a couple of cycles after this.
  task automatic begin_period();
    wait_until(longint'(FRAME_CYC) * pcount);
    if (pcount > 0) begin
      if (mq.size() > 0) last_pair = mq.pop_front();
      else               exp_under++;
    end
    sb.push_back(frame_word(last_pair));
    pcount++;
    wait_until(longint'(FRAME_CYC) * (pcount - 1) + 100);
  endtask

  task automatic write_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    bit cand;
    bit exp_o;
    bus.APSDATA_LEFT_i  = l;
    bus.APSDATA_RIGHT_i = r;
    bus.APDATA_VALID_i  = 1'b1;
`ifdef I2S_TX_DOWNSAMPLE_2X_EN
    cand   = !ds_tog;
    ds_tog = !ds_tog;
`else
    cand = 1'b1;
`endif
    exp_o = 1'b0;
    if (cand) begin
      if (mq.size() == DEPTH) begin
        exp_o = 1'b1;
        exp_ovf++;
      end else begin
        mq.push_back({l, r});
      end
    end
    tick();
    bus.APDATA_VALID_i = 1'b0;
    check("overflow_pulse", 64'(bus.OVERFLOW_o), 64'(exp_o));
    check("fifo_level", 64'(bus.FIFO_LEVEL_o), 64'(mq.size()));
  endtask

  task automatic rand_write();
    write_pair(SW'($urandom), SW'($urandom));
  endtask

  initial begin
    int n;
    int t;
    bus.APSDATA_LEFT_i  = '0;
    bus.APSDATA_RIGHT_i = '0;
    bus.APDATA_VALID_i  = 1'b0;
    repeat (3) tick();
    check("rst_bck",      64'(bus.I2S_BCK),      64'd0);
    check("rst_ws",       64'(bus.I2S_WS),       64'd0);
    check("rst_data",     64'(bus.I2S_DATA),     64'd0);
    check("rst_level",    64'(bus.FIFO_LEVEL_o), 64'd0);
    check("rst_underrun", 64'(bus.UNDERRUN_o),   64'd0);
    check("rst_overflow", 64'(bus.OVERFLOW_o),   64'd0);
    tick();
    ARST_i = 1'b0;
    rel    = cyc;

    begin_period();
    begin_period();
    begin_period();
    write_pair(24'h800001, 24'h7FFFFE);
    begin_period();
    for (int i = 0; i < 6; i++) rand_write();
    begin_period();
    begin_period();
    begin_period();
    write_pair(24'h123456, 24'h654321);
    for (int i = 0; i < 4; i++) begin_period();

    for (int p = 0; p < 8; p++) begin
      begin_period();
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        rand_write();
        if ($urandom_range(0, 1) == 1) tick();
      end
    end

    // Reset in the middle of a right slot, with data still buffered.
    begin_period();
    rand_write();
    rand_write();
    wait_until(longint'(FRAME_CYC) * (pcount - 1) + 330);
    ARST_i = 1'b1;
    #1;
    check("arst_bck",   64'(bus.I2S_BCK),      64'd0);
    check("arst_ws",    64'(bus.I2S_WS),       64'd0);
    check("arst_data",  64'(bus.I2S_DATA),     64'd0);
    check("arst_level", 64'(bus.FIFO_LEVEL_o), 64'd0);
    sb.delete();
    mq.delete();
    last_pair = '0;
    pcount    = 0;
    ds_tog    = 1'b0;
    repeat (3) tick();
    ARST_i = 1'b0;
    rel    = cyc;

    begin_period();
    begin_period();
    rand_write();
    begin_period();
    begin_period();

    t = 0;
    while (sb.size() > 0 && t < 2000) begin
      tick();
      t++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("underrun_count", 64'(mon_under), 64'(exp_under));
    check("overflow_count", 64'(mon_ovf),   64'(exp_ovf));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Parallel-to-I2S transmitter, the counterpart of the codebase's I2S receiver. It accepts 24-bit stereo sample pairs from the FIR/interpolation path on the AMCLK domain.
- Buffers samples in a small FIFO and generates BCK/WS as master. Serializes standard Philips I2S with 32-bit slots.
- Feeds the HDMI/audio-DAC output of the board's audio chain.

Parameters:
- SAMPLE_W, 24, sample width in bits; valid range 16..31.
- BCK_HALF, 4, AMCLK cycles per BCK half-period; BCK = AMCLK/(2*BCK_HALF); must be ≥ 2.
- FIFO_DEPTH, 4, sample-pair FIFO entries; power of two.

Ports:
- AMCLK_i  in  1  audio master clock; the only clock.
- ARST_i  in  1  asynchronous active-high reset.
- APSDATA_LEFT_i  in  SAMPLE_W  left sample, signed two's complement.
- APSDATA_RIGHT_i  in  SAMPLE_W  right sample, signed.
- APDATA_VALID_i  in  1  one-cycle strobe; the pair is written when high.
- I2S_BCK  out  1  bit clock.
- I2S_WS  out  1  word select; 0 = left, 1 = right.
- I2S_DATA  out  1  serial data, MSB first.
- FIFO_LEVEL_o  out  clog2(FIFO_DEPTH)+1  current occupancy.
- UNDERRUN_o  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- OVERFLOW_o  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (async assert, sync deassert internally): BCK=0, WS=0, DATA=0, div_cnt=0, bit_cnt=0, frame shift register=0, last-pair register=0, FIFO empty, both pulses 0.
- Prescaler: div_cnt counts 0..BCK_HALF-1. At terminal count it wraps and BCK toggles.
  - "fall event" = the cycle BCK is driven 1→0.
  - "rise event" = the cycle BCK is driven 0→1.
- bit_cnt (6 bits, 0..63) advances on each fall event and wraps 63→0.
- WS, DATA and bit_cnt all update only on fall events, so they are stable across every BCK rising edge.
- Slot map, indexed by bit_cnt after the update:
  - WS = bit_cnt[5].
  - DATA at slot 0 = 0.
  - Slots 1..SAMPLE_W = left MSB..LSB.
  - Slots SAMPLE_W+1..31 = 0.
  - Slot 32 = 0.
  - Slots 33..32+SAMPLE_W = right MSB..LSB.
  - Remaining slots = 0.
  - This is the I2S one-BCK delay after each WS edge.
- Frame load happens on the fall event where bit_cnt wraps 63→0:
  - FIFO non-empty: pop the head pair into the frame register and the last-pair register.
  - FIFO empty: reload the last-pair register, which holds the previous pair or zero after reset, and pulse UNDERRUN_o.
- Latency: a write to an empty FIFO drives its left MSB on I2S_DATA at the fall event of slot 1 of the next frame; worst case ≈ 64×2×BCK_HALF+2×BCK_HALF AMCLK cycles.
- FIFO write:
  - On APDATA_VALID_i with the FIFO not full, push.
  - When full, drop the pair and pulse OVERFLOW_o; the FIFO contents are unchanged.
  - If a pop and a push occur in the same cycle with the FIFO full, both succeed; the level is unchanged and there is no overflow.
  - If a pop and a push occur in the same cycle with the FIFO empty, the pushed pair is not popped that cycle (no bypass); underrun is flagged.
- FIFO_LEVEL_o is registered and updates the cycle after a push or pop.
- The frame state machine is implicit in bit_cnt: LEFT_SLOT (0..31) → RIGHT_SLOT (32..63) → LEFT_SLOT. There are no other states.
- ARST_i asserted mid-frame forces all reset values immediately; output restarts at bit_cnt=0 with zero data.

Optional Feature:
- Macro: I2S_TX_DOWNSAMPLE_2X_EN.
- Defined:
  - A toggle flop, reset to 0, flips on every APDATA_VALID_i.
  - Only strobes arriving while the toggle is 0 are written to the FIFO (1st, 3rd, 5th, ...).
  - Discarded strobes never raise OVERFLOW_o.
- Undefined: every strobe is a write candidate.

Decomposition:
- Shared package i2s_pkg:
  - SLOT_W=32.
  - FRAME_BITS=64.
  - WS_LEFT=1'b0.
  - Function clog2.
- Sub-module i2s_tx_fifo: synchronous FIFO, 2×SAMPLE_W wide, FIFO_DEPTH deep, with push/pop/full/empty/level and async active-high reset.

Test Plan (all with BCK_HALF=4, so one BCK = 8 AMCLK cycles and one frame = 512 AMCLK cycles):
1. Reset released, no input → BCK toggles every 4 AMCLK; WS toggles every 256 AMCLK; DATA stays 0; UNDERRUN_o pulses once per 512 cycles.
2. Write L=0x800001, R=0x7FFFFE → next frame serializes slot 0 = 0, slots 1..24 = 1000…0001, slots 25..31 = 0, then right pattern 0111…1110 in slots 33..56.
3. Write 6 pairs back-to-back with FIFO_DEPTH=4 → FIFO_LEVEL_o reaches 4; OVERFLOW_o pulses on the 5th and 6th writes; the first 4 pairs are transmitted in order.
4. Stop input after pair 0x123456/0x654321 → subsequent frames repeat that pair; UNDERRUN_o pulses at each frame start.
5. Assert ARST_i at bit_cnt=40 → within the same cycle BCK, WS, DATA = 0 and FIFO_LEVEL_o = 0; after release, the first frame is zero.
6. With I2S_TX_DOWNSAMPLE_2X_EN defined, write 8 pairs → exactly pairs 0, 2, 4, 6 are transmitted; no overflow pulse.
